// File: rtl/stk_op_sequencer.sv
// Instruction sequencer and stack-port arbiter for the stack-machine datapath.
// Optional ALU watchdog enabled by defining SEQ_TIMEOUT_EN.
module stk_op_sequencer #(
   parameter int DATA_LEN  = 8,
   parameter int STK_DEPTH = 8,
   parameter int DEPTH_W   = 4,
   parameter int TIMEOUT   = 32
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [1:0]          instr_op,
   input  logic [DATA_LEN-1:0] instr_imm,
   output logic [3:0]          alu_ctrl,
   input  logic                alu_push,
   input  logic                alu_pop,
   input  logic [DATA_LEN-1:0] alu_data,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [DATA_LEN-1:0] stk_data_in,
   output logic [DEPTH_W-1:0]  depth,
   output logic                err,
   output logic [1:0]          err_code,
   input  logic                err_clr
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      ALU_WAIT = 2'b01,
      ERR      = 2'b10
   } state_t;

   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;
   localparam logic [1:0] OP_SUB  = 2'b11;

   localparam logic [1:0] CODE_NONE  = 2'b00;
   localparam logic [1:0] CODE_OVF   = 2'b01;
   localparam logic [1:0] CODE_UNF   = 2'b10;
   localparam logic [1:0] CODE_TMO   = 2'b11;

   localparam logic [DEPTH_W-1:0] FULL    = DEPTH_W'(STK_DEPTH);
   localparam logic [DEPTH_W-1:0] MIN_OPS = DEPTH_W'(2);

   state_t              state;
   logic                push_r;
   logic [DATA_LEN-1:0] data_r;
   logic                alu_push_v;
   logic                alu_pop_v;

`ifdef SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] tmo_cnt;
`endif

   // Undriven or unknown ALU request lines must read as inactive.
   assign alu_push_v = (alu_push === 1'b1);
   assign alu_pop_v  = (alu_pop === 1'b1);

   function automatic logic [DEPTH_W-1:0] sat_depth(input logic [DEPTH_W-1:0] d,
                                                    input logic pop, input logic push);
      logic [DEPTH_W-1:0] t;
      t = d;
      if (pop && (t != '0))
         t = t - 1'b1;
      if (push && (t < FULL))
         t = t + 1'b1;
      return t;
   endfunction

   assign instr_ready = (state == IDLE) && !push_r;
   assign err         = (state == ERR);

   always_comb begin
      stk_push    = push_r;
      stk_pop     = 1'b0;
      stk_data_in = data_r;
      if (state == ALU_WAIT) begin
         stk_push    = alu_push_v;
         stk_pop     = alu_pop_v;
         stk_data_in = alu_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         push_r   <= 1'b0;
         data_r   <= '0;
         alu_ctrl <= 4'b0000;
         depth    <= '0;
         err_code <= CODE_NONE;
`ifdef SEQ_TIMEOUT_EN
         tmo_cnt  <= '0;
`endif
      end else begin
         push_r   <= 1'b0;
         alu_ctrl <= 4'b0000;
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  case (instr_op)
                     OP_PUSH: begin
                        if (depth == FULL) begin
                           state    <= ERR;
                           err_code <= CODE_OVF;
                        end else begin
                           push_r <= 1'b1;
                           data_r <= instr_imm;
                           depth  <= depth + 1'b1;
                        end
                     end
                     OP_ADD, OP_SUB: begin
                        if (depth < MIN_OPS) begin
                           state    <= ERR;
                           err_code <= CODE_UNF;
                        end else begin
                           // bit0 selects add, bits 2:1 are the start strobe
                           alu_ctrl <= {1'b0, 2'b11, (instr_op == OP_ADD)};
                           state    <= ALU_WAIT;
`ifdef SEQ_TIMEOUT_EN
                           tmo_cnt  <= '0;
`endif
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ALU_WAIT: begin
               depth <= sat_depth(depth, alu_pop_v, alu_push_v);
               if (alu_push_v) begin
                  state <= IDLE;
               end
`ifdef SEQ_TIMEOUT_EN
               else if (tmo_cnt == CNT_LAST) begin
                  state    <= ERR;
                  err_code <= CODE_TMO;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
`endif
            end
            ERR: begin
               if (err_clr) begin
                  state    <= IDLE;
                  err_code <= CODE_NONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_stk_op_sequencer.sv
// Bench for stk_op_sequencer: behavioural ALU and stack, queue-based reference model.
module tb_stk_op_sequencer;
   localparam int DL = 8;
   localparam int SD = 8;
   localparam int DW = 4;
   localparam int TO = 32;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [1:0]    instr_op = 2'b00;
   logic [DL-1:0] instr_imm = '0;
   logic [3:0]    alu_ctrl;
   logic          alu_push, alu_pop;
   logic [DL-1:0] alu_data;
   logic          stk_push, stk_pop;
   logic [DL-1:0] stk_data_in;
   logic [DW-1:0] depth;
   logic          err;
   logic [1:0]    err_code;
   logic          err_clr = 1'b0;

   always #5 clk = ~clk;

   stk_op_sequencer #(.DATA_LEN(DL), .STK_DEPTH(SD), .DEPTH_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rstn(rstn),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_imm(instr_imm),
      .alu_ctrl(alu_ctrl), .alu_push(alu_push), .alu_pop(alu_pop), .alu_data(alu_data),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_data_in(stk_data_in),
      .depth(depth), .err(err), .err_code(err_code), .err_clr(err_clr)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: operand stack contents and error expectation
   logic [DL-1:0] mq[$];
   bit            exp_err = 0;
   bit            settled = 0;
   bit            stub = 1'b0;

   // Behavioural stack memory fed by the DUT stack port
   logic [DL-1:0] smem[0:15];
   int            sp;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sp <= 0;
      end else begin
         sp <= sp - ((stk_pop === 1'b1 && sp > 0) ? 1 : 0) + ((stk_push === 1'b1 && sp < 16) ? 1 : 0);
         if (stk_push === 1'b1 && sp < 16)
            smem[sp - ((stk_pop === 1'b1 && sp > 0) ? 1 : 0)] <= stk_data_in;
      end
   end

   // Behavioural ALU: pop a, pop b, a few idle cycles, push a op b
   initial begin
      logic          is_add;
      logic [DL-1:0] a, b;
      alu_push = 1'b0;
      alu_pop  = 1'b0;
      alu_data = '0;
      forever begin
         @(posedge clk); #1;
         if (rstn && !stub && alu_ctrl[2:1] == 2'b11) begin
            is_add  = alu_ctrl[0];
            a       = smem[sp-1];
            alu_pop = 1'b1;
            @(posedge clk); #1;
            b       = smem[sp-1];
            @(posedge clk); #1;
            alu_pop = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            alu_data = is_add ? a + b : a - b;
            alu_push = 1'b1;
            @(posedge clk); #1;
            alu_push = 1'b0;
         end
      end
   end

   // Per-cycle comparison whenever the sequencer is settled between instructions
   always @(negedge clk) begin
      if (settled && rstn) begin
         chk("cyc_depth", depth, mq.size());
         chk("cyc_err", err, exp_err);
         chk("cyc_ctrl_bit3", alu_ctrl[3], 0);
      end
   end

   task automatic issue(input logic [1:0] op, input logic [DL-1:0] imm);
      int            n;
      bit            e;
      logic [1:0]    code;
      logic [DL-1:0] a, b, r;
      settled = 0;
      e = 0;
      code = 2'b00;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op    = op;
      instr_imm   = imm;
      n = 0;
      while (!instr_ready && n < 50) begin @(negedge clk); n++; end
      if (!instr_ready) begin
         chk("accept_timeout", 0, 1);
         instr_valid = 1'b0;
         return;
      end
      case (op)
         2'b01: if (mq.size() == SD) begin e = 1; code = 2'b01; end
                else mq.push_back(imm);
         2'b10, 2'b11: begin
            if (mq.size() < 2) begin e = 1; code = 2'b10; end
            else begin
               a = mq.pop_back();
               b = mq.pop_back();
               r = (op == 2'b10) ? a + b : a - b;
               mq.push_back(r);
            end
         end
         default: ;
      endcase
      exp_err = e;
      @(negedge clk);
      instr_valid = 1'b0;
      instr_op    = 2'b00;
      if (e) begin
         chk("err_set", err, 1);
         chk("err_code", err_code, code);
         chk("err_ctrl_quiet", alu_ctrl, 0);
         chk("err_no_pop", stk_pop, 0);
         chk("err_no_push", stk_push, 0);
      end else begin
         case (op)
            2'b01: begin
               chk("push_strobe", stk_push, 1);
               chk("push_data", stk_data_in, imm);
               chk("push_ready_low", instr_ready, 0);
            end
            2'b10: chk("add_ctrl", alu_ctrl, 4'b0111);
            2'b11: chk("sub_ctrl", alu_ctrl, 4'b0110);
            default: chk("nop_ready", instr_ready, 1);
         endcase
         if (op[1]) begin
            @(negedge clk);
            chk("ctrl_one_cycle", alu_ctrl, 0);
         end
      end
      n = 0;
      while (!(instr_ready || err) && n < 100) begin @(negedge clk); n++; end
      chk("complete", instr_ready || err, 1);
      chk("depth", depth, mq.size());
      chk("err", err, e);
      if (e) chk("err_code_held", err_code, code);
      chk("stack_ptr", sp, mq.size());
      if (!e && mq.size() > 0) chk("stack_top", smem[sp-1], mq[$]);
      settled = 1;
   endtask

   task automatic clear_err();
      settled = 0;
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_err = 0;
      chk("clr_ready", instr_ready, 1);
      chk("clr_err", err, 0);
      chk("clr_code", err_code, 0);
      chk("clr_depth", depth, mq.size());
      settled = 1;
   endtask

   task automatic do_reset();
      settled = 0;
      @(negedge clk);
      rstn = 1'b0;
      instr_valid = 1'b0;
      err_clr = 1'b0;
      mq.delete();
      exp_err = 0;
      #1;
      chk("rst_ready", instr_ready, 1);
      chk("rst_ctrl", alu_ctrl, 0);
      chk("rst_push", stk_push, 0);
      chk("rst_pop", stk_pop, 0);
      chk("rst_data", stk_data_in, 0);
      chk("rst_depth", depth, 0);
      chk("rst_err", err, 0);
      chk("rst_code", err_code, 0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_release_ready", instr_ready, 1);
      settled = 1;
   endtask

   // Starts an ADD toward a non-responding ALU; returns at the first negedge after accept
   task automatic start_stub_add();
      settled = 0;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op    = 2'b10;
      @(negedge clk);
      instr_valid = 1'b0;
      instr_op    = 2'b00;
      chk("stub_add_ctrl", alu_ctrl, 4'b0111);
   endtask

   initial begin
      int n;
      logic [1:0] op;
      do_reset();

      // PUSH 5, PUSH 3, ADD -> 8
      issue(2'b01, 8'd5);
      issue(2'b01, 8'd3);
      issue(2'b10, 8'd0);
      chk("lit_add_top", smem[sp-1], 8);
      chk("lit_add_depth", depth, 1);
      chk("lit_add_err", err, 0);

      // PUSH 2, PUSH 9, SUB -> 9 - 2
      do_reset();
      issue(2'b01, 8'd2);
      issue(2'b01, 8'd9);
      issue(2'b11, 8'd0);
      chk("lit_sub_top", smem[sp-1], 7);
      chk("lit_sub_depth", depth, 1);

      // Overflow on the ninth PUSH
      do_reset();
      for (int i = 0; i < SD + 1; i++) issue(2'b01, 8'(i + 1));
      chk("lit_ovf_code", err_code, 1);
      chk("lit_ovf_depth", depth, 8);
      chk("lit_ovf_top", smem[sp-1], 8);
      clear_err();
      chk("lit_ovf_clr_depth", depth, 8);

      // Underflow: ADD with one operand
      do_reset();
      issue(2'b01, 8'd1);
      issue(2'b10, 8'd0);
      chk("lit_unf_code", err_code, 2);
      chk("lit_unf_ctrl", alu_ctrl, 0);
      clear_err();

      // NOP has no effect
      issue(2'b00, 8'd77);

      // Stub ALU that never answers
      do_reset();
      issue(2'b01, 8'd4);
      issue(2'b01, 8'd6);
      stub = 1'b1;
      start_stub_add();
      n = 1;
`ifdef SEQ_TIMEOUT_EN
      while (!err && n < TO + 20) begin @(negedge clk); n++; end
      chk("tmo_cycles", n, TO + 1);
      chk("tmo_code", err_code, 3);
      chk("tmo_ctrl", alu_ctrl, 0);
      chk("tmo_depth", depth, 2);
      exp_err = 1;
      clear_err();
      start_stub_add();
`else
      repeat (200) @(negedge clk);
      chk("wait_ready", instr_ready, 0);
      chk("wait_err", err, 0);
      chk("wait_depth", depth, 2);
`endif
      // Reset while waiting on the ALU
      repeat (3) @(negedge clk);
      do_reset();
      stub = 1'b0;

      // Randomized instruction stream
      for (int i = 0; i < 80; i++) begin
         n  = $urandom_range(0, 9);
         op = (n < 5) ? 2'b01 : (n < 7) ? 2'b10 : (n < 9) ? 2'b11 : 2'b00;
         issue(op, 8'($urandom));
         if (exp_err) clear_err();
      end

      settled = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got 1 expected 0");
      $fatal(1);
   end

endmodule

// File: doc/stk_op_sequencer.md
# stk_op_sequencer

Instruction sequencer and stack-port arbiter for the stack-machine datapath. It accepts a stream of PUSH/ADD/SUB/NOP instructions and writes immediates to the operand stack itself. For arithmetic it starts the ALU through its 4-bit control bus, then hands the stack port to the ALU until the result is pushed. It tracks stack depth to flag overflow and underflow before the stack or ALU is touched.

## Interface
- DATA_LEN, 8, operand/immediate width
- STK_DEPTH, 8, stack capacity in entries
- DEPTH_W, 4, depth counter width; must hold STK_DEPTH
- TIMEOUT, 32, ALU watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rstn  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr_op  in  2  00 NOP, 01 PUSH, 10 ADD, 11 SUB
- instr_imm  in  DATA_LEN  PUSH immediate
- alu_ctrl  out  4  ALU control bus: bit0 = 1 for add, 0 for sub; bits1 and 2 = start; bit3 = 0
- alu_push, alu_pop  in  1  ALU stack requests; only the value 1 counts, 0/z/x = inactive
- alu_data  in  DATA_LEN  ALU result toward the stack
- stk_push, stk_pop  out  1  to the stack
- stk_data_in  out  DATA_LEN  to the stack
- depth  out  DEPTH_W  current stack occupancy
- err  out  1  sticky error
- err_code  out  2  01 overflow, 10 underflow, 11 ALU timeout, 00 none
- err_clr  in  1  clears the error; active in ERR only

## Operation
- States:
  - IDLE: instr_ready = 1 unless the push register is set.
  - ALU_WAIT: instr_ready = 0.
  - ERR: instr_ready = 0; err = 1.
- An instruction is accepted on an edge where instr_valid & instr_ready.
- NOP: consumed; no effect.
- PUSH with depth < STK_DEPTH:
  - Registers stk_push = 1 and stk_data_in = imm for exactly one cycle.
  - depth + 1.
  - Remains in IDLE.
- PUSH with depth == STK_DEPTH: goes to ERR with code 01; no push is issued.
- ADD/SUB with depth < 2: goes to ERR with code 10; the ALU is not started.
- ADD/SUB with depth >= 2:
  - alu_ctrl = 4'b0111 (ADD) or 4'b0110 (SUB) for exactly one cycle, then 4'b0000.
  - Goes to ALU_WAIT.
- ALU_WAIT:
  - stk_push/stk_pop/stk_data_in are a combinational pass-through of alu_push (as 0/1), alu_pop (as 0/1) and alu_data.
  - Each cycle with alu_pop == 1: depth − 1.
  - A cycle with alu_push == 1: depth + 1 and IDLE on the next edge.
  - Net effect of a completed op: depth − 1.
- Outside ALU_WAIT, ALU requests are ignored and not forwarded.
- ERR:
  - err_code is held; depth is frozen.
  - err_clr → IDLE with err = 0, err_code = 00, depth unchanged.
- depth saturates: it never wraps below 0 or above STK_DEPTH. Excess ALU pops are ignored for counting.

## Timing
- Reset values: state IDLE, instr_ready 1, alu_ctrl 0, stk_push 0, stk_pop 0, stk_data_in 0, depth 0, err 0, err_code 00.
- Reset mid-operation aborts any op immediately. alu_ctrl = 0 during reset, so the ALU (sharing rstn) also resets.
- PUSH accepted at edge N:
  - stk_push high in cycle N+1.
  - instr_ready low in N+1, high again in N+2.
- ADD/SUB accepted at edge N:
  - Start bits high in cycle N+1 only.
  - Completion is one cycle after the alu_push cycle.
  - With the standard 8-state ALU, the next instruction is accepted about 10 cycles after N.
- Error detected at accept edge N: err = 1 from cycle N+1.
- err_clr at edge M: instr_ready = 1 from M+1.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A cycle counter runs in ALU_WAIT.
  - If TIMEOUT cycles pass without alu_push, go to ERR with code 11 and set alu_ctrl = 0.
- SEQ_TIMEOUT_EN undefined: ALU_WAIT waits indefinitely; code 11 is never produced.

## Test plan
- Reset, then PUSH 5, PUSH 3, ADD with the real ALU → stack top 8, depth 1, err 0.
- PUSH 2, PUSH 9, SUB → pushed result = 9 − 2 = 7 (first pop minus second pop), depth 1.
- STK_DEPTH+1 PUSHes → last one not pushed, err 1, err_code 01, depth 8; err_clr → instr_ready 1, depth 8.
- ADD with depth 1 → err_code 10, alu_ctrl stays 0, no stk_pop.
- ADD with a stub ALU that never pushes → with SEQ_TIMEOUT_EN, err_code 11 at TIMEOUT cycles; without it, still in ALU_WAIT at 200 cycles.
- rstn low during ALU_WAIT → all outputs at reset values, depth 0, instr_ready 1 after release.
